// File: rtl/cache_arb_pkg.sv
// Shared types and helpers for the cache request arbiters.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY
  } arb_state_t;

  // Watchdog counter width: enough to hold TIMEOUT, never narrower than one bit.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate requests so ptr sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick #(
  parameter int SEL_WIDTH = 3,
  localparam int N = 2 ** SEL_WIDTH
) (
  input  logic [N-1:0]         req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [SEL_WIDTH-1:0] winner,
  output logic                 any
);

  logic [2*N-1:0]       doubled;
  logic [N-1:0]         rotated;
  logic [SEL_WIDTH-1:0] offset;

  assign doubled = {req, req};
  assign rotated = doubled[ptr +: N];
  assign any     = |req;

  always_comb begin
    offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) offset = SEL_WIDTH'(i);
    end
  end

  // Modulo-N add back to an absolute index; the SEL_WIDTH-bit sum wraps on its own.
  assign winner = offset + ptr;

endmodule

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing the cache request port: grant, one-cycle valid,
// wait for done, with a watchdog that aborts transactions the cache never answers.
module cache_req_arbiter
  import cache_arb_pkg::*;
#(
  parameter int SEL_WIDTH = 3,
  parameter int TIMEOUT   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2**SEL_WIDTH-1:0]   req,
  input  logic                      cache_done,
  output logic [SEL_WIDTH-1:0]      sel,
  output logic [2**SEL_WIDTH-1:0]   gnt,
  output logic                      cache_valid,
  output logic [2**SEL_WIDTH-1:0]   ack,
  output logic                      err,
  output logic                      busy
);

  localparam int N  = 2 ** SEL_WIDTH;
  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [N-1:0]  ONE   = N'(1);

  arb_state_t           state_reg;
  logic [SEL_WIDTH-1:0] ptr_reg;
  logic [CW-1:0]        cnt_reg;

  logic [N-1:0]         masked;
  logic [SEL_WIDTH-1:0] win;
  logic                 any;

  // The requester being acknowledged this cycle has not yet seen its ack.
  assign masked = req & ~ack;

  rr_pick #(.SEL_WIDTH(SEL_WIDTH)) u_pick (
    .req    (masked),
    .ptr    (ptr_reg),
    .winner (win),
    .any    (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      cnt_reg     <= '0;
      sel         <= '0;
      gnt         <= '0;
      cache_valid <= 1'b0;
      ack         <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      cache_valid <= 1'b0;
      ack         <= '0;
      err         <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any) begin
            state_reg   <= ISSUE;
            sel         <= win;
            gnt         <= ONE << win;
            cache_valid <= 1'b1;
            busy        <= 1'b1;
          end
        end
        ISSUE: begin
          state_reg <= BUSY;
        end
        BUSY: begin
          // Completion takes priority over an abort landing in the same cycle.
          if (cache_done) begin
            state_reg <= IDLE;
            ack       <= gnt;
            gnt       <= '0;
            ptr_reg   <= sel + 1'b1;
            cnt_reg   <= '0;
            busy      <= 1'b0;
          end else if (TIMEOUT != 0 && cnt_reg == LIMIT) begin
            state_reg <= IDLE;
            err       <= 1'b1;
            gnt       <= '0;
            ptr_reg   <= sel + 1'b1;
            cnt_reg   <= '0;
            busy      <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
